// File: rtl/arb_rr_hold.sv
// ---------------------------------------------------------------------------
// arb_rr_hold
//   Round-robin arbiter for two requesters. Each grant tenure is capped at
//   MAX_HOLD cycles. When GAP_EN is set, one grant-free cycle separates
//   tenures. Two saturating counters record how many tenures each requester
//   has started, for coverage and debug.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles per tenure (1..255)
//   GAP_EN   : 1 = one idle cycle between tenures, 0 = back-to-back handover
//   CNT_W    : width of the per-requester tenure counters
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   request  : level-sensitive request vector, bit i = requester i
//   grant    : registered one-hot grant, 2'b00 = no owner
//   busy     : high whenever grant is non-zero
//   hold_cnt : 0-based cycle count inside the current tenure, 0 when idle
//   gnt_cnt0 : tenures started by requester 0, saturating
//   gnt_cnt1 : tenures started by requester 1, saturating
// ---------------------------------------------------------------------------
module arb_rr_hold #(
    parameter int MAX_HOLD = 8,
    parameter int GAP_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       request,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [7:0]       hold_cnt,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Last legal value of the 0-based hold counter; reaching it ends the tenure.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [7:0]       hold_q,  hold_d;
    logic             ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt0_q,  cnt0_d;
    logic [CNT_W-1:0] cnt1_q,  cnt1_d;

    logic             start;
    logic             start_idx;
    logic             owner;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Grant is one-hot while in S_GRANT, so bit 1 alone identifies the owner.
    assign owner = grant_q[1];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        start     = 1'b0;
        start_idx = 1'b0;

        case (state_q)
            S_IDLE, S_GAP: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                hold_d  = 8'd0;
                if (request != 2'b00) begin
                    start     = 1'b1;
                    // Contention is resolved by the pointer; a single request wins outright.
                    start_idx = (request == 2'b11) ? ptr_q : request[1];
                end
            end

            S_GRANT: begin
                if (!request[owner] || (hold_q == HOLD_LAST)) begin
                    ptr_d   = ~owner;
                    grant_d = 2'b00;
                    hold_d  = 8'd0;
                    if (GAP_EN != 0) begin
                        state_d = S_GAP;
                    end else if (request[~owner]) begin
                        start     = 1'b1;
                        start_idx = ~owner;
                    end else if (request[owner]) begin
                        // Only reachable on expiry: the owner restarts a fresh tenure.
                        start     = 1'b1;
                        start_idx = owner;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                hold_d  = 8'd0;
            end
        endcase

        // Every tenure start, from any state, restarts the hold count and bumps the owner's counter.
        if (start) begin
            state_d = S_GRANT;
            grant_d = start_idx ? 2'b10 : 2'b01;
            hold_d  = 8'd0;
            if (start_idx) begin
                cnt1_d = sat_inc(cnt1_q);
            end else begin
                cnt0_d = sat_inc(cnt0_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            hold_q  <= 8'd0;
            ptr_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = |grant_q;
    assign hold_cnt = hold_q;
    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// ---------------------------------------------------------------------------
// tb_arb_rr_hold
//   Drives two arbiter instances from one directed sequence:
//     u_a : MAX_HOLD=8, GAP_EN=1, CNT_W=4  (gap handover, counter saturation)
//     u_b : MAX_HOLD=8, GAP_EN=0, CNT_W=16 (back-to-back handover, re-grant)
//   Expected outputs are queued before each clock edge and compared after it.
// ---------------------------------------------------------------------------
module tb_arb_rr_hold;

    logic        clk;
    logic        reset;
    logic [1:0]  req_a, req_b;
    logic [1:0]  gnt_a, gnt_b;
    logic        busy_a, busy_b;
    logic [7:0]  hold_a, hold_b;
    logic [3:0]  c0_a, c1_a;
    logic [15:0] c0_b, c1_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         dut;
        logic [1:0] g;
        int         h;
        int         c0;
        int         c1;
    } exp_t;

    exp_t sb[$];

    arb_rr_hold #(.MAX_HOLD(8), .GAP_EN(1), .CNT_W(4)) u_a (
        .clk      (clk),
        .reset    (reset),
        .request  (req_a),
        .grant    (gnt_a),
        .busy     (busy_a),
        .hold_cnt (hold_a),
        .gnt_cnt0 (c0_a),
        .gnt_cnt1 (c1_a)
    );

    arb_rr_hold #(.MAX_HOLD(8), .GAP_EN(0), .CNT_W(16)) u_b (
        .clk      (clk),
        .reset    (reset),
        .request  (req_b),
        .grant    (gnt_b),
        .busy     (busy_b),
        .hold_cnt (hold_b),
        .gnt_cnt0 (c0_b),
        .gnt_cnt1 (c1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int dut, input logic [1:0] g,
                        input int h, input int c0, input int c1);
        exp_t e;
        e.tag = tag; e.dut = dut; e.g = g; e.h = h; e.c0 = c0; e.c1 = c1;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] g, bz, h, c0, c1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                g = 32'(gnt_a); bz = 32'(busy_a); h = 32'(hold_a); c0 = 32'(c0_a); c1 = 32'(c1_a);
            end else begin
                g = 32'(gnt_b); bz = 32'(busy_b); h = 32'(hold_b); c0 = 32'(c0_b); c1 = 32'(c1_b);
            end
            cmp($sformatf("%s.grant", e.tag), g,  32'(e.g));
            cmp($sformatf("%s.busy",  e.tag), bz, 32'(|e.g));
            if (e.h  >= 0) cmp($sformatf("%s.hold", e.tag), h,  32'(e.h));
            if (e.c0 >= 0) cmp($sformatf("%s.cnt0", e.tag), c0, 32'(e.c0));
            if (e.c1 >= 0) cmp($sformatf("%s.cnt1", e.tag), c1, 32'(e.c1));
        end
    endtask

    // Structural properties that hold every cycle regardless of stimulus.
    task automatic invariants(input logic [1:0] pa, input logic [1:0] pb);
        cmp("a.not11",   32'(gnt_a == 2'b11), 32'd0);
        cmp("b.not11",   32'(gnt_b == 2'b11), 32'd0);
        cmp("a.reqd",    32'(gnt_a & ~pa), 32'd0);
        cmp("b.reqd",    32'(gnt_b & ~pb), 32'd0);
        cmp("a.holdmax", 32'(hold_a < 8'd8), 32'd1);
        cmp("b.holdmax", 32'(hold_b < 8'd8), 32'd1);
        cmp("a.idlehold", 32'((gnt_a == 2'b00) && (hold_a != 8'd0)), 32'd0);
        cmp("b.idlehold", 32'((gnt_b == 2'b00) && (hold_b != 8'd0)), 32'd0);
    endtask

    task automatic tick();
        logic [1:0] pa, pb;
        pa = req_a;
        pb = req_b;
        @(posedge clk);
        #1;
        drain();
        invariants(pa, pb);
    endtask

    // Expected view while both requesters are held high from the first grant (t=0).
    // per=9 models a gap cycle after each 8-cycle tenure, per=8 back-to-back.
    task automatic exp_cont(input int t, input int per, output logic [1:0] g,
                            output int h, output int c0, output int c1);
        int k, p;
        k = t / per;
        p = t % per;
        if (p >= 8) begin
            g = 2'b00; h = 0;
        end else begin
            g = (k % 2 == 0) ? 2'b01 : 2'b10; h = p;
        end
        c0 = k / 2 + 1;
        c1 = (k + 1) / 2;
    endtask

    initial begin
        logic [1:0] g;
        int h, c0, c1;

        reset = 1'b0;
        req_a = 2'b11;
        req_b = 2'b11;
        #1;
        push("rst0", 0, 2'b00, 0, 0, 0);
        push("rst0", 1, 2'b00, 0, 0, 0);
        drain();

        // Reset held across three edges with both requesting.
        for (int i = 0; i < 3; i++) begin
            push("rst", 0, 2'b00, 0, 0, 0);
            push("rst", 1, 2'b00, 0, 0, 0);
            tick();
        end
        reset = 1'b1;

        // Contention: requester 0 first, then alternation.
        for (int t = 0; t <= 32; t++) begin
            exp_cont(t, 9, g, h, c0, c1);
            push($sformatf("contA[%0d]", t), 0, g, h, c0, c1);
            exp_cont(t, 8, g, h, c0, c1);
            push($sformatf("contB[%0d]", t), 1, g, h, c0, c1);
            tick();
            cmp("a.fair", 32'((c0_a >= c1_a ? c0_a - c1_a : c1_a - c0_a) <= 4'd1), 32'd1);
        end

        // u_a now owned by requester 1 with hold_cnt=5; reset between edges.
        #3;
        reset = 1'b0;
        #1;
        push("asyncrst", 0, 2'b00, 0, 0, 0);
        push("asyncrst", 1, 2'b00, 0, 0, 0);
        drain();
        #1;
        reset = 1'b1;

        // Restart with both requesting, then requester 0 of u_b releases early.
        for (int t = 0; t <= 2; t++) begin
            exp_cont(t, 9, g, h, c0, c1);
            push($sformatf("restartA[%0d]", t), 0, g, h, c0, c1);
            exp_cont(t, 8, g, h, c0, c1);
            push($sformatf("restartB[%0d]", t), 1, g, h, c0, c1);
            tick();
        end
        req_b = 2'b10;
        exp_cont(3, 9, g, h, c0, c1);
        push("relA[3]", 0, g, h, c0, c1);
        push("relB.handover", 1, 2'b10, 0, 1, 1);
        tick();
        exp_cont(4, 9, g, h, c0, c1);
        push("relA[4]", 0, g, h, c0, c1);
        push("relB.keep", 1, 2'b10, 1, 1, 1);
        tick();

        // Clean start for the single-owner runs.
        req_a = 2'b00;
        req_b = 2'b00;
        reset = 1'b0;
        #1;
        push("rst2", 0, 2'b00, 0, 0, 0);
        push("rst2", 1, 2'b00, 0, 0, 0);
        drain();
        reset = 1'b1;
        req_a = 2'b01;
        req_b = 2'b01;

        // Single owner: u_a expires into a gap then re-grants, its 4-bit counter
        // saturates at 15; u_b re-grants back-to-back on every expiry.
        for (int t = 0; t < 200; t++) begin
            int k;
            k = t / 9;
            if (t % 9 < 8) g = 2'b01; else g = 2'b00;
            push($sformatf("soloA[%0d]", t), 0, g, (t % 9 < 8) ? t % 9 : 0,
                 (k + 1 > 15) ? 15 : k + 1, 0);
            push($sformatf("soloB[%0d]", t), 1, 2'b01, t % 8, t / 8 + 1, 0);
            tick();
        end

        // Random level requests; structural checks run inside tick().
        for (int i = 0; i < 10000; i++) begin
            req_a = 2'($urandom_range(0, 3));
            req_b = 2'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
